// File: rtl/morse_pkg.sv
// Shared types and the letter table for the Morse transmitter.
// Table entry: len = symbol count, pattern bit0 = first symbol, 1 = dash.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MARK = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0] len;
        logic [3:0] pattern;
    } sym_t;

    localparam logic [2:0] LETTER_A = 3'd0;
    localparam logic [2:0] LETTER_B = 3'd1;
    localparam logic [2:0] LETTER_C = 3'd2;
    localparam logic [2:0] LETTER_D = 3'd3;
    localparam logic [2:0] LETTER_E = 3'd4;
    localparam logic [2:0] LETTER_F = 3'd5;
    localparam logic [2:0] LETTER_G = 3'd6;
    localparam logic [2:0] LETTER_H = 3'd7;

    localparam logic [1:0] DASH_UNITS = 2'd3;
    localparam logic [1:0] GAP_UNITS  = 2'd1;

    function automatic sym_t letter_table(input logic [2:0] code);
        sym_t s;
        case (code)
            LETTER_A: s = '{len: 3'd2, pattern: 4'b0010};
            LETTER_B: s = '{len: 3'd4, pattern: 4'b0001};
            LETTER_C: s = '{len: 3'd4, pattern: 4'b0101};
            LETTER_D: s = '{len: 3'd3, pattern: 4'b0001};
            LETTER_E: s = '{len: 3'd1, pattern: 4'b0000};
            LETTER_F: s = '{len: 3'd4, pattern: 4'b0100};
            LETTER_G: s = '{len: 3'd3, pattern: 4'b0011};
            default:  s = '{len: 3'd4, pattern: 4'b0000};
        endcase
        return s;
    endfunction

endpackage

// File: rtl/morse_transmitter_unit_timer.sv
// Rate divider: down-counter that pulses unit_tick once every TICKS cycles.
// restart reloads the full period so a new state always gets a whole unit.
module unit_timer #(
    parameter int unsigned TICKS = 25_000_000
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic restart,
    output logic unit_tick
);

    localparam int unsigned CW = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TICKS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q - 1'b1;
        if (restart || (cnt_q == '0)) begin
            cnt_d = LOAD;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign unit_tick = (cnt_q == '0);

endmodule

// File: rtl/morse_transmitter.sv
// Serialises one letter (A-H) onto light as Morse marks and gaps.
// Handshake: start is taken only in IDLE; busy covers MARK/GAP, done pulses once at the end.
module morse_transmitter
    import morse_pkg::*;
#(
    parameter int unsigned TICKS_PER_UNIT = 25_000_000
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       start,
    input  logic [2:0] letter,
    output logic       light,
    output logic       busy,
    output logic       done,
    output state_t     state_dbg
);

    state_t     state_q, state_d;
    logic [3:0] pat_q, pat_d;
    logic [2:0] rem_q, rem_d;
    logic [1:0] unit_q, unit_d;
    logic       restart;
    logic       unit_tick;
    logic [1:0] mark_last;
    sym_t       sym;

    unit_timer #(.TICKS(TICKS_PER_UNIT)) u_timer (
        .Clock     (Clock),
        .Resetn    (Resetn),
        .restart   (restart),
        .unit_tick (unit_tick)
    );

    assign sym       = letter_table(letter);
    assign mark_last = pat_q[0] ? (DASH_UNITS - 2'd1) : 2'd0;

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        rem_d   = rem_q;
        unit_d  = unit_q;
        restart = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d   = sym.pattern;
                    rem_d   = sym.len;
                    unit_d  = '0;
                    restart = 1'b1;
                    state_d = MARK;
                end
            end
            MARK: begin
                if (unit_tick) begin
                    if (unit_q == mark_last) begin
                        unit_d  = '0;
                        restart = 1'b1;
                        state_d = GAP;
                    end else begin
                        unit_d = unit_q + 2'd1;
                    end
                end
            end
            GAP: begin
                if (unit_tick) begin
                    if (unit_q == (GAP_UNITS - 2'd1)) begin
                        // Advance to the next symbol; the last one ends the letter.
                        unit_d  = '0;
                        pat_d   = pat_q >> 1;
                        rem_d   = rem_q - 3'd1;
                        restart = 1'b1;
                        state_d = (rem_q == 3'd1) ? DONE : MARK;
                    end else begin
                        unit_d = unit_q + 2'd1;
                    end
                end
            end
            DONE: begin
                restart = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= IDLE;
            pat_q   <= '0;
            rem_q   <= '0;
            unit_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            rem_q   <= rem_d;
            unit_q  <= unit_d;
        end
    end

    assign light     = (state_q == MARK);
    assign busy      = (state_q == MARK) || (state_q == GAP);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

endmodule
